// File: rtl/brick_hit_controller.sv
// brick_hit_controller: sequences brick_memory for level init sweeps and hit read-modify-writes.
// Tracks the surviving brick count and raises level_clear once they are all gone.
module brick_hit_controller #(
    parameter int COLS         = 10,
    parameter int ROWS         = 8,
    parameter int BRICK_W      = 32,
    parameter int BRICK_H      = 16,
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int INIT_HEALTH  = 3,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req,
    input  logic             hit_valid,
    input  logic [9:0]       hit_x,
    input  logic [9:0]       hit_y,
    output logic             hit_ready,
    output logic             busy,
    output logic             result_valid,
    output logic             result_hit,
    output logic             result_destroyed,
    output logic [1:0]       result_health,
    output logic [CNT_W-1:0] bricks_left,
    output logic             level_clear,
    output logic [9:0]       mem_x,
    output logic [9:0]       mem_y,
    output logic             mem_wren,
    output logic [1:0]       mem_health,
    input  logic [1:0]       mem_q
);
    typedef enum logic [2:0] {IDLE, INIT, RD, WR, RESP} state_t;

    localparam logic [9:0]       C_LAST  = 10'(COLS - 1);
    localparam logic [9:0]       R_LAST  = 10'(ROWS - 1);
    localparam logic [9:0]       BW      = 10'(BRICK_W);
    localparam logic [9:0]       BH      = 10'(BRICK_H);
    localparam logic [9:0]       XS      = 10'(X0);
    localparam logic [9:0]       YS      = 10'(Y0);
    localparam logic [1:0]       IH      = 2'(INIT_HEALTH);
    localparam logic [15:0]      RL_LAST = 16'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] N_BRICK = CNT_W'(COLS * ROWS);

    state_t           state_q;
    logic [9:0]       col_q, row_q, mem_x_q, mem_y_q;
    logic [15:0]      rd_cnt_q;
    logic [1:0]       q_q, mem_health_q, result_health_q;
    logic             mem_wren_q, result_valid_q, result_hit_q, result_destroyed_q, init_done_q;
    logic [CNT_W-1:0] bricks_left_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            col_q              <= '0;
            row_q              <= '0;
            mem_x_q            <= '0;
            mem_y_q            <= '0;
            rd_cnt_q           <= '0;
            q_q                <= '0;
            mem_wren_q         <= 1'b0;
            mem_health_q       <= '0;
            result_valid_q     <= 1'b0;
            result_hit_q       <= 1'b0;
            result_destroyed_q <= 1'b0;
            result_health_q    <= '0;
            bricks_left_q      <= '0;
            init_done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q      <= INIT;
                        col_q        <= '0;
                        row_q        <= '0;
                        mem_x_q      <= XS;
                        mem_y_q      <= YS;
                        mem_wren_q   <= 1'b1;
                        mem_health_q <= IH;
                    end else if (hit_valid) begin
                        state_q  <= RD;
                        mem_x_q  <= hit_x;
                        mem_y_q  <= hit_y;
                        rd_cnt_q <= '0;
                    end
                end
                INIT: begin
                    // Column advances fastest; coordinates step by adders, never multiplied.
                    if (col_q == C_LAST && row_q == R_LAST) begin
                        state_q       <= IDLE;
                        mem_wren_q    <= 1'b0;
                        mem_health_q  <= '0;
                        bricks_left_q <= N_BRICK;
                        init_done_q   <= 1'b1;
                    end else if (col_q == C_LAST) begin
                        col_q   <= '0;
                        row_q   <= row_q + 10'd1;
                        mem_x_q <= XS;
                        mem_y_q <= mem_y_q + BH;
                    end else begin
                        col_q   <= col_q + 10'd1;
                        mem_x_q <= mem_x_q + BW;
                    end
                end
                RD: begin
                    if (rd_cnt_q == RL_LAST) begin
                        state_q      <= WR;
                        q_q          <= mem_q;
                        mem_wren_q   <= mem_q != 2'd0;
                        mem_health_q <= mem_q == 2'd0 ? 2'd0 : mem_q - 2'd1;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                end
                WR: begin
                    state_q            <= RESP;
                    mem_wren_q         <= 1'b0;
                    mem_health_q       <= '0;
                    result_valid_q     <= 1'b1;
                    result_hit_q       <= q_q != 2'd0;
                    result_destroyed_q <= q_q == 2'd1;
                    result_health_q    <= q_q == 2'd0 ? 2'd0 : q_q - 2'd1;
                    if (q_q == 2'd1 && bricks_left_q != '0)
                        bricks_left_q <= bricks_left_q - 1'b1;
                end
                RESP: begin
                    state_q        <= IDLE;
                    result_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hit_ready        = (state_q == IDLE) & ~init_req;
    assign busy             = state_q != IDLE;
    assign result_valid     = result_valid_q;
    assign result_hit       = result_hit_q;
    assign result_destroyed = result_destroyed_q;
    assign result_health    = result_health_q;
    assign bricks_left      = bricks_left_q;
    assign level_clear      = init_done_q & (bricks_left_q == '0);
    assign mem_x            = mem_x_q;
    assign mem_y            = mem_y_q;
    assign mem_wren         = mem_wren_q;
    assign mem_health       = mem_health_q;
endmodule

// File: tb/tb_brick_hit_controller.sv
// tb_brick_hit_controller: directed bench with a transaction-age reference model for the default
// configuration and literal checks for a small 2x1 grid with two-cycle read latency.
module tb_brick_hit_controller;
    localparam int COLS = 10, N = 80, BW = 32, BH = 16, L = 1, IH = 3;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input int x, input int y, input int c);
        return (y / BH) * c + x / BW;
    endfunction

    logic       init_req = 0, hit_valid = 0;
    logic [9:0] hit_x = 0, hit_y = 0;
    logic       hit_ready, busy, result_valid, result_hit, result_destroyed, level_clear, mem_wren;
    logic [1:0] result_health, mem_health, mem_q;
    logic [9:0] bricks_left, mem_x, mem_y;

    brick_hit_controller d0 (
        .clk(clk), .reset(reset), .init_req(init_req), .hit_valid(hit_valid),
        .hit_x(hit_x), .hit_y(hit_y), .hit_ready(hit_ready), .busy(busy),
        .result_valid(result_valid), .result_hit(result_hit),
        .result_destroyed(result_destroyed), .result_health(result_health),
        .bricks_left(bricks_left), .level_clear(level_clear), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wren(mem_wren), .mem_health(mem_health), .mem_q(mem_q)
    );

    logic [1:0] mem0 [N];
    assign mem_q = mem0[idx(mem_x, mem_y, COLS) % N];
    always @(posedge clk) if (mem_wren) mem0[idx(mem_x, mem_y, COLS) % N] <= mem_health;

    logic       init1 = 0, hv1 = 0;
    logic [9:0] hx1 = 0, hy1 = 0;
    logic       ready1, busy1, rv1, rhit1, rdest1, lc1, wren1;
    logic [1:0] rh1, health1, mem_q1, q1;
    logic [9:0] bl1, x1, y1;

    brick_hit_controller #(.COLS(2), .ROWS(1), .INIT_HEALTH(1), .READ_LATENCY(2)) d1 (
        .clk(clk), .reset(reset), .init_req(init1), .hit_valid(hv1),
        .hit_x(hx1), .hit_y(hy1), .hit_ready(ready1), .busy(busy1),
        .result_valid(rv1), .result_hit(rhit1), .result_destroyed(rdest1),
        .result_health(rh1), .bricks_left(bl1), .level_clear(lc1), .mem_x(x1), .mem_y(y1),
        .mem_wren(wren1), .mem_health(health1), .mem_q(mem_q1)
    );

    // Two-cycle memory: address registered, data returned the following cycle.
    logic [1:0] mem1 [2];
    assign mem_q1 = q1;
    always @(posedge clk) begin
        if (wren1) mem1[idx(x1, y1, 2) % 2] <= health1;
        q1 <= mem1[idx(x1, y1, 2) % 2];
    end

    initial begin
        foreach (mem0[i]) mem0[i] = 2'd0;
        foreach (mem1[i]) mem1[i] = 2'd0;
    end

    // Reference model: kind 0 idle, 1 init sweep, 2 hit; age counts cycles since the accept edge.
    int kind = 0, age = 0, mhx = 0, mhy = 0, mq = 0, bl = 0, idone = 0, rh = 0, rd = 0, rhl = 0;
    int hmodel [N];
    bit started = 0;
    bit mwr;

    initial foreach (hmodel[i]) hmodel[i] = 0;

    always @(posedge clk) begin
        if (kind == 1) hmodel[age-1] = IH;
        if (kind == 2 && age == L) mq = hmodel[idx(mhx, mhy, COLS) % N];
        if (kind == 2 && age == L + 1 && mq != 0) hmodel[idx(mhx, mhy, COLS) % N] = mq - 1;
        if (reset) begin
            kind = 0; age = 0; bl = 0; idone = 0; rh = 0; rd = 0; rhl = 0; started = 1;
        end else if (kind == 0) begin
            if (init_req) begin kind = 1; age = 1; end
            else if (hit_valid) begin kind = 2; age = 1; mhx = hit_x; mhy = hit_y; end
        end else if (kind == 1) begin
            if (age == N) begin kind = 0; bl = N; idone = 1; end
            else age++;
        end else begin
            if (age == L + 1) begin
                if (mq == 1 && bl > 0) bl--;
                rh = mq != 0; rd = mq == 1; rhl = mq != 0 ? mq - 1 : 0;
            end
            if (age == L + 2) kind = 0;
            else age++;
        end
    end

    always @(negedge clk) if (started) begin
        mwr = kind == 2 && age == L + 1 && mq != 0;
        chk("m_busy", busy, kind != 0);
        chk("m_hit_ready", hit_ready, kind == 0 && !init_req);
        chk("m_mem_wren", mem_wren, kind == 1 || mwr);
        chk("m_mem_health", mem_health, kind == 1 ? IH : mwr ? mq - 1 : 0);
        chk("m_result_valid", result_valid, kind == 2 && age == L + 2);
        chk("m_result_hit", result_hit, rh);
        chk("m_result_destroyed", result_destroyed, rd);
        chk("m_result_health", result_health, rhl);
        chk("m_bricks_left", bricks_left, bl);
        chk("m_level_clear", level_clear, idone == 1 && bl == 0);
        if (kind == 1) begin
            chk("m_init_x", mem_x, ((age - 1) % COLS) * BW);
            chk("m_init_y", mem_y, ((age - 1) / COLS) * BH);
        end
        if (kind == 2 && age <= L + 1) begin
            chk("m_hit_x", mem_x, mhx);
            chk("m_hit_y", mem_y, mhy);
        end
    end

    task automatic hit(input int x, input int y, input int eh, input int ed, input int ev);
        hit_valid = 1; hit_x = 10'(x); hit_y = 10'(y);
        tick();
        hit_valid = 0;
        chk("rd_wren", mem_wren, 0); chk("rd_x", mem_x, x); chk("rd_y", mem_y, y);
        tick();
        chk("wr_wren", mem_wren, eh);
        if (eh != 0) chk("wr_health", mem_health, ev);
        tick();
        chk("res_valid", result_valid, 1); chk("res_hit", result_hit, eh);
        chk("res_destroyed", result_destroyed, ed); chk("res_health", result_health, ev);
        tick();
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        chk("rst_busy", busy, 0); chk("rst_bricks_left", bricks_left, 0);
        chk("rst_wren", mem_wren, 0); chk("rst_result_valid", result_valid, 0);
        chk("rst_hit_ready", hit_ready, 1); chk("rst_level_clear", level_clear, 0);

        init_req = 1; tick(); init_req = 0;
        for (int k = 0; k < N; k++) begin
            chk("init_wren", mem_wren, 1);
            if (k == 0) begin chk("w0_x", mem_x, 0); chk("w0_y", mem_y, 0); chk("w0_h", mem_health, 3); end
            if (k == 10) begin chk("w10_x", mem_x, 0); chk("w10_y", mem_y, 16); end
            if (k == 79) begin chk("w79_x", mem_x, 288); chk("w79_y", mem_y, 112); end
            tick();
        end
        chk("init_bricks_left", bricks_left, 80); chk("init_level_clear", level_clear, 0);
        chk("init_busy", busy, 0);

        hit(40, 20, 1, 0, 2);
        hit(40, 20, 1, 0, 1);
        hit(40, 20, 1, 1, 0);
        chk("destroy_bricks_left", bricks_left, 79);
        hit(40, 20, 0, 0, 0);
        chk("miss_bricks_left", bricks_left, 79);

        init_req = 1; hit_valid = 1; hit_x = 100; hit_y = 50;
        #1 chk("both_hit_ready", hit_ready, 0);
        tick(); init_req = 0;
        for (int k = 0; k < N; k++) begin
            chk("reinit_busy", busy, 1); chk("reinit_ready", hit_ready, 0);
            if (k == 40) chk("reinit_keep_bl", bricks_left, 79);
            tick();
        end
        chk("reinit_bricks_left", bricks_left, 80); chk("late_ready", hit_ready, 1);
        tick(); hit_valid = 0;
        chk("late_rd_x", mem_x, 100); chk("late_rd_y", mem_y, 50);
        tick(); tick();
        chk("late_result_valid", result_valid, 1); chk("late_result_health", result_health, 2);
        tick();

        hit_valid = 1; hit_x = 0; hit_y = 0; tick(); hit_valid = 0; tick();
        chk("wr_cycle_wren", mem_wren, 1);
        reset = 1; tick(); reset = 0;
        chk("rstwr_wren", mem_wren, 0); chk("rstwr_busy", busy, 0);
        chk("rstwr_result_valid", result_valid, 0); chk("rstwr_bricks_left", bricks_left, 0);
        chk("rstwr_level_clear", level_clear, 0);
        tick();
        chk("rstwr_no_result", result_valid, 0);

        init_req = 1; tick(); init_req = 0;
        repeat (29) tick();
        chk("w29_x", mem_x, 288); chk("w29_y", mem_y, 32);
        reset = 1; tick(); reset = 0;
        chk("rstinit_wren", mem_wren, 0); chk("rstinit_busy", busy, 0);
        chk("rstinit_bricks_left", bricks_left, 0); chk("rstinit_level_clear", level_clear, 0);

        init1 = 1; tick(); init1 = 0; tick(); tick();
        chk("s_bricks_left", bl1, 2); chk("s_level_clear", lc1, 0); chk("s_busy", busy1, 0);
        for (int b = 0; b < 2; b++) begin
            hv1 = 1; hx1 = 10'(b * 32); hy1 = 0;
            tick(); hv1 = 0; tick(); tick();
            chk("s_wr_rv", rv1, 0); chk("s_wr_wren", wren1, 1); chk("s_wr_health", health1, 0);
            chk("s_wr_lc", lc1, 0);
            tick();
            chk("s_rv", rv1, 1); chk("s_hit", rhit1, 1); chk("s_destroyed", rdest1, 1);
            chk("s_health", rh1, 0); chk("s_bricks_left_after", bl1, 1 - b); chk("s_level_clear", lc1, b);
            tick();
            chk("s_rv_drop", rv1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brick_hit_controller.md
Name: brick_hit_controller

Overview:
Client and sequencer for the brick health store (brick_memory). On a level-start request it sweeps the whole brick grid and writes the initial health into every brick. On each ball-hit request it runs a read-modify-write: read the health, decrement it if non-zero, write it back, then report the outcome. It tracks the number of surviving bricks and flags level clear to the game FSM.

Parameters:
COLS, 10, bricks per row
ROWS, 8, brick rows (COLS*ROWS <= 1023)
BRICK_W, 32, brick width in pixels
BRICK_H, 16, brick height in pixels
X0, 0, pixel x of brick (0,0)
Y0, 0, pixel y of brick (0,0)
INIT_HEALTH, 3, health written by the init sweep (2-bit, non-zero)
READ_LATENCY, 1, cycles from address presented to mem_q valid (>=1)
CNT_W, 10, width of bricks_left

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init_req  in  1  start grid fill; sampled only in IDLE
hit_valid  in  1  hit request valid
hit_x  in  10  pixel x of hit
hit_y  in  10  pixel y of hit
hit_ready  out  1  request accepted when hit_valid & hit_ready
busy  out  1  high in any non-IDLE state
result_valid  out  1  one-cycle pulse, hit outcome
result_hit  out  1  brick had health > 0
result_destroyed  out  1  health went 1 -> 0
result_health  out  2  health after the hit (0 on miss)
bricks_left  out  CNT_W  surviving bricks
level_clear  out  1  init done and bricks_left == 0
mem_x  out  10  pixel x to the memory block
mem_y  out  10  pixel y to the memory block
mem_wren  out  1  memory write enable
mem_health  out  2  write data to the memory block
mem_q  in  2  read data from the memory block

Behaviour:
- Reset: state IDLE. All outputs 0 except hit_ready: mem_x, mem_y, mem_wren, mem_health, result_*, bricks_left, level_clear, busy all 0, and the init_done flag is 0. Memory contents are not touched.
- hit_ready = (state==IDLE) & ~init_req.
- States: IDLE, INIT, RD, WR, RESP.
- IDLE, init_req=1: go to INIT. init_req has priority over hit_valid.
- IDLE, hit_valid & hit_ready: latch hit_x and hit_y, go to RD.
- INIT:
  - One brick per cycle, row-major with column fastest.
  - mem_x = X0 + col*BRICK_W and mem_y = Y0 + row*BRICK_H, generated by incremental adders (no multipliers).
  - mem_wren=1, mem_health=INIT_HEALTH.
  - Exactly COLS*ROWS write cycles, then IDLE.
  - On the cycle INIT exits: bricks_left = COLS*ROWS, init_done = 1.
- RD: mem_x and mem_y hold the latched coordinates, mem_wren=0. Stay READ_LATENCY cycles. mem_q is sampled on the final RD edge into q_reg.
- WR, one cycle:
  - Latched address held.
  - If q_reg != 0: mem_wren=1, mem_health = q_reg - 1.
  - If q_reg == 0: mem_wren=0 and no write.
  - Health never underflows.
- RESP, one cycle: result_valid=1 and back to IDLE.
  - result_hit = (q_reg != 0).
  - result_health = result_hit ? q_reg - 1 : 0.
  - result_destroyed = (q_reg == 1).
- Result fields are held until the next result. result_valid is 0 outside RESP.
- bricks_left decrements by 1 on the WR edge when q_reg == 1. It saturates at 0.
- Latency with the accept edge as cycle 0:
  - RD occupies cycles 1..READ_LATENCY.
  - WR occurs at READ_LATENCY+1.
  - result_valid occurs at READ_LATENCY+2.
  - The next accept is possible at READ_LATENCY+3.
  - Latency is fixed for both hit and miss.
- level_clear = init_done & (bricks_left == 0). A new init_req clears it by reloading bricks_left when INIT completes. init_done stays 1 during re-init.
- hit_valid while busy: ignored, no queuing. init_req while busy: ignored.
- Reset in any state, including mid-INIT or in WR: IDLE on the next edge. mem_wren drops that cycle, the pending result is dropped (no result_valid), and bricks_left and init_done clear.
- Outside INIT and WR, mem_wren=0 and mem_health=0.

Test Plan:
1. Reset, then a 1-cycle init_req -> busy for 80 cycles with mem_wren=1 every cycle. First write is (0,0) health 3, 11th write is (0,16), last write is (288,112). Afterwards bricks_left=80, level_clear=0.
2. After init, hit (40,20) accepted at cycle 0 -> cycle 1 RD with mem_wren=0 and mem_x/y=(40,20). Cycle 2 mem_wren=1, mem_health=2. Cycle 3 result_valid=1, hit=1, destroyed=0, health=2.
3. Three more hits on the same brick -> healths 1 then 0. The third hit gives destroyed=1 and bricks_left=79. A fourth hit gives hit=0, health 0, and no mem_wren pulse.
4. init_req and hit_valid high in the same IDLE cycle -> hit_ready=0 and INIT runs. The hit is accepted on the first IDLE cycle after the 80 writes.
5. Reset asserted during the WR cycle, and again mid-INIT at write 30 -> next cycle mem_wren=0, busy=0, no result_valid, bricks_left=0.
6. COLS=2, ROWS=1, INIT_HEALTH=1, READ_LATENCY=2 with a behavioural memory model: init, then hit both bricks -> result_valid at cycle 4 after each accept, and level_clear=1 on the cycle after the second WR.
